// File: rtl/instr_sequencer.sv
// instr_sequencer: small instruction FIFO in front of a one-at-a-time decoder/FSM
// that drives the shared datapath (regfile, A/B/C regs, shifter, ALU, status).
// Optional build macro SEQ_PERF_CNT_EN adds instr_cnt/busy_cnt performance counters.
// Handshake: a word transfers on the rising edge where in_valid and in_ready are both 1;
// in_ready depends only on FIFO occupancy (never on in_valid), and a full FIFO refuses
// the push even if a pop happens on the same edge.
// state_dbg mirrors the FSM state for debug and assertion binding.
module instr_sequencer #(
   parameter int FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] instr,
   output logic [2:0]  r_num,
   output logic [2:0]  w_num,
   output logic        w_en,
   output logic [1:0]  wb_sel,
   output logic [15:0] sximm8,
   output logic [1:0]  shift_op,
   output logic [1:0]  ALU_op,
   output logic        en_A,
   output logic        en_B,
   output logic        en_C,
   output logic        en_status,
   output logic        sel_A,
   output logic        sel_B,
   output logic        idle,
   output logic        done,
   output logic        illegal,
   output logic [2:0]  state_dbg
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [15:0] instr_cnt,
   output logic [15:0] busy_cnt
`endif
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_GET_A  = 3'd1,
      S_GET_B  = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_WB_IMM = 3'd5,
      S_BAD    = 3'd6
   } state_t;

   state_t        state;
   logic [15:0]   ir;
   logic [15:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic [15:0]   head;

   // Decode helpers for the popped word (head) and the current IR.
   logic h_movi, h_mov, h_mvn, h_alu3;
   logic ir_cmp;

   assign full      = (count == FULL_CNT);
   assign empty     = (count == '0);
   assign in_ready  = ~full;
   assign push      = in_valid & ~full;
   assign pop       = (state == S_IDLE) & ~empty;
   assign head      = mem[rd_ptr];

   assign h_movi    = (head[15:11] == 5'b11010);
   assign h_mov     = (head[15:11] == 5'b11000);
   assign h_mvn     = (head[15:11] == 5'b10111);
   assign h_alu3    = (head[15:13] == 3'b101) & ~h_mvn;
   assign ir_cmp    = (ir[15:11] == 5'b10101);

   assign sximm8    = {{8{ir[7]}}, ir[7:0]};
   assign sel_B     = 1'b0;
   assign idle      = (state == S_IDLE) & empty;
   assign state_dbg = state;

   // MOV forces the ALU to pass-through (op 00); otherwise the opcode's op field.
   function automatic logic [1:0] alu_op_of(input logic [15:0] w);
      return (w[15:13] == 3'b110) ? 2'b00 : w[12:11];
   endfunction

   // MOV and MVN take only the shifted Rm, so the A operand is forced to zero.
   function automatic logic sel_a_of(input logic [15:0] w);
      return (w[15:13] == 3'b110) | (w[12:11] == 2'b11);
   endfunction

   // FIFO storage: written on an accepted push, no reset needed for the data.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= instr;
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   // Sequencing FSM: every output is registered and set for the state being entered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         ir        <= '0;
         r_num     <= '0;
         w_num     <= '0;
         w_en      <= 1'b0;
         wb_sel    <= '0;
         shift_op  <= '0;
         ALU_op    <= '0;
         en_A      <= 1'b0;
         en_B      <= 1'b0;
         en_C      <= 1'b0;
         en_status <= 1'b0;
         sel_A     <= 1'b0;
         done      <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         r_num     <= '0;
         w_num     <= '0;
         w_en      <= 1'b0;
         wb_sel    <= '0;
         shift_op  <= '0;
         ALU_op    <= '0;
         en_A      <= 1'b0;
         en_B      <= 1'b0;
         en_C      <= 1'b0;
         en_status <= 1'b0;
         sel_A     <= 1'b0;
         done      <= 1'b0;
         illegal   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pop) begin
                  ir <= head;
                  if (h_alu3) begin
                     state <= S_GET_A;
                     r_num <= head[10:8];
                     en_A  <= 1'b1;
                  end else if (h_mov | h_mvn) begin
                     state    <= S_GET_B;
                     r_num    <= head[2:0];
                     en_B     <= 1'b1;
                     ALU_op   <= alu_op_of(head);
                     sel_A    <= sel_a_of(head);
                     shift_op <= head[4:3];
                  end else if (h_movi) begin
                     state  <= S_WB_IMM;
                     w_num  <= head[10:8];
                     wb_sel <= 2'b10;
                     w_en   <= 1'b1;
                     done   <= 1'b1;
                  end else begin
                     state   <= S_BAD;
                     illegal <= 1'b1;
                  end
               end
            end
            S_GET_A: begin
               state    <= S_GET_B;
               r_num    <= ir[2:0];
               en_B     <= 1'b1;
               ALU_op   <= alu_op_of(ir);
               sel_A    <= sel_a_of(ir);
               shift_op <= ir[4:3];
            end
            S_GET_B: begin
               state    <= S_EXEC;
               ALU_op   <= alu_op_of(ir);
               sel_A    <= sel_a_of(ir);
               shift_op <= ir[4:3];
               if (ir_cmp) begin
                  en_status <= 1'b1;
                  done      <= 1'b1;
               end else begin
                  en_C <= 1'b1;
               end
            end
            S_EXEC: begin
               if (ir_cmp) begin
                  state <= S_IDLE;
               end else begin
                  state    <= S_WB;
                  ALU_op   <= alu_op_of(ir);
                  sel_A    <= sel_a_of(ir);
                  shift_op <= ir[4:3];
                  w_num    <= ir[7:5];
                  wb_sel   <= 2'b00;
                  w_en     <= 1'b1;
                  done     <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef SEQ_PERF_CNT_EN
   // Performance counters: completed instructions and non-idle cycles, wrapping at 16 bits.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instr_cnt <= '0;
         busy_cnt  <= '0;
      end else begin
         if (done)              instr_cnt <= instr_cnt + 16'd1;
         if (state != S_IDLE)   busy_cnt  <= busy_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a driver pushes words and queues the
// expected per-instruction activity; a monitor rebuilds that activity from the
// datapath control outputs and compares it when done/illegal closes an instruction.
module tb_instr_sequencer;
  localparam int DEPTH = 2;
  localparam int W = 51;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        in_ready;
  logic [2:0]  r_num, w_num;
  logic        w_en;
  logic [1:0]  wb_sel, shift_op, ALU_op;
  logic [15:0] sximm8;
  logic        en_A, en_B, en_C, en_status, sel_A, sel_B, idle, done, illegal;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int pushes = 0;
  int pops = 0;
  int refusals = 0;
  logic [W-1:0] exp_q[$];

  instr_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .r_num(r_num), .w_num(w_num), .w_en(w_en), .wb_sel(wb_sel), .sximm8(sximm8),
    .shift_op(shift_op), .ALU_op(ALU_op), .en_A(en_A), .en_B(en_B), .en_C(en_C),
    .en_status(en_status), .sel_A(sel_A), .sel_B(sel_B), .idle(idle), .done(done),
    .illegal(illegal), .state_dbg(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what one instruction word should do to the datapath controls.
  // Record: {cycles, illegal, done, readA, Rn, readB, Rm, trip@B, trip@exec, status,
  //          write, wnum, wbsel, trip@write, imm}; trip = {ALU_op, sel_A, shift_op}.
  function automatic logic [W-1:0] model(input logic [15:0] w);
    logic [2:0] opc = w[15:13];
    logic [1:0] op = w[12:11];
    logic [2:0] cyc = 0, a_n = 0, b_n = 0, w_n = 0;
    logic ill = 0, d = 0, a_v = 0, b_v = 0, st = 0, w_v = 0;
    logic [4:0] tb = 0, tx = 0, tw = 0, trip;
    logic [1:0] ws = 0;
    logic [15:0] imm = 0;
    if (opc == 3'b110 && op == 2'b10) begin
      cyc = 1; d = 1; w_v = 1; w_n = w[10:8]; ws = 2'b10;
      imm = {{8{w[7]}}, w[7:0]};
    end else if (opc == 3'b110 && op == 2'b00) begin
      trip = {2'b00, 1'b1, w[4:3]};
      cyc = 3; d = 1; b_v = 1; b_n = w[2:0]; tb = trip; tx = trip;
      w_v = 1; w_n = w[7:5]; ws = 2'b00; tw = trip;
    end else if (opc == 3'b101) begin
      trip = {op, (op == 2'b11), w[4:3]};
      d = 1; b_v = 1; b_n = w[2:0]; tb = trip; tx = trip;
      if (op != 2'b11) begin a_v = 1; a_n = w[10:8]; end
      if (op == 2'b01) begin
        cyc = 3; st = 1;
      end else begin
        cyc = (op == 2'b11) ? 3'd3 : 3'd4;
        w_v = 1; w_n = w[7:5]; ws = 2'b00; tw = trip;
      end
    end else begin
      cyc = 1; ill = 1;
    end
    return {cyc, ill, d, a_v, a_n, b_v, b_n, tb, tx, st, w_v, w_n, ws, tw, imm};
  endfunction

  // driver: offer one word from a negedge, wait (bounded) for acceptance, queue expectation
  task automatic send(input logic [15:0] w);
    int waits = 0;
    in_valid = 1'b1;
    instr = w;
    while (!in_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      check("send_accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    if (waits > 0) refusals++;
    @(posedge clk);
    pushes++;
    exp_q.push_back(model(w));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !idle) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_within_budget", 64'(n < 2000), 64'd1);
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w = 16'($urandom);
    case ($urandom_range(0, 7))
      0, 1: w[15:11] = 5'b11010;
      2: w[15:11] = 5'b11000;
      3, 4, 5: w[15:13] = 3'b101;
      default: ;
    endcase
    return w;
  endfunction

  // scoreboard monitor: rebuilds each instruction's activity and compares at its end
  logic       prev_active = 0, prev_end = 0;
  int         a_cyc = 0;
  logic       a_ill, a_d, a_av, a_bv, a_st, a_wv;
  logic [2:0] a_an, a_bn, a_wn;
  logic [4:0] a_tb, a_tx, a_tw;
  logic [1:0] a_ws;
  logic [15:0] a_imm;

  always @(negedge clk) begin : monitor
    int n_act;
    int occ;
    logic active, start;
    if (!rst_n) begin
      exp_q.delete();
      pushes = 0;
      pops = 0;
      prev_active = 0;
      prev_end = 0;
      a_cyc = 0;
    end else begin
      n_act = int'(en_A) + int'(en_B) + int'(en_C) + int'(en_status) + int'(w_en) + int'(illegal);
      active = (n_act != 0);
      start = active && (!prev_active || prev_end);
      if (active) check("idle_cycle_between_instrs", 64'(prev_end), 64'd0);
      if (start) begin
        pops++;
        a_cyc = 0; a_ill = 0; a_d = 0; a_av = 0; a_bv = 0; a_st = 0; a_wv = 0;
        a_an = 0; a_bn = 0; a_wn = 0; a_tb = 0; a_tx = 0; a_tw = 0; a_ws = 0; a_imm = 0;
      end
      occ = pushes - pops;
      check("in_ready", 64'(in_ready), 64'(occ < DEPTH));
      check("idle", 64'(idle), 64'(!active && occ == 0));
      check("sel_B", 64'(sel_B), 64'd0);
      if (active) begin
        check("one_enable_per_cycle", 64'(n_act), 64'd1);
        a_cyc++;
        if (en_A) begin a_av = 1; a_an = r_num; end
        if (en_B) begin a_bv = 1; a_bn = r_num; a_tb = {ALU_op, sel_A, shift_op}; end
        if (en_C || en_status) begin a_tx = {ALU_op, sel_A, shift_op}; a_st = a_st | en_status; end
        if (w_en) begin
          a_wv = 1; a_wn = w_num; a_ws = wb_sel; a_tw = {ALU_op, sel_A, shift_op};
          if (wb_sel == 2'b10) a_imm = sximm8;
        end
        if (illegal) a_ill = 1;
        if (done) a_d = 1;
      end else begin
        check("quiet_outputs", 64'({r_num, w_num, wb_sel, shift_op, ALU_op, sel_A, done}), 64'd0);
      end
      if (active && (done || illegal)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr_end: got activity with no queued word (state %0d) at %0t",
                   dbg_state, $time);
        end else begin
          check("instr_activity",
                64'({3'(a_cyc), a_ill, a_d, a_av, a_an, a_bv, a_bn, a_tb, a_tx, a_st,
                     a_wv, a_wn, a_ws, a_tw, a_imm}),
                64'(exp_q.pop_front()));
        end
        prev_end = 1;
      end else begin
        prev_end = 0;
      end
      prev_active = active;
    end
  end

  // main stimulus
  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_outputs",
          64'({r_num, w_num, w_en, wb_sel, shift_op, ALU_op, en_A, en_B, en_C, en_status,
               sel_A, done, illegal}), 64'd0);
    check("rst_sximm8", 64'(sximm8), 64'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // directed words
    send(16'hD0FF); drain();
    send(16'hA048); drain();
    send(16'hA801); drain();
    send(16'hB8F3); drain();
    send(16'hC06A); drain();
    send(16'hE000); send(16'hD57F); drain();

    // back-pressure: three words offered while an ADD is running
    send(16'hA048);
    refusals = 0;
    send(16'hD183); send(16'hA1B2); send(16'hB065);
    check("burst_backpressure_seen", 64'(refusals > 0), 64'd1);
    drain();

    // randomized stream
    repeat (300) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(rand_word());
    end
    drain();

    // reset while an ADD is in EXEC: aborted, no write
    send(16'hA048);
    n = 0;
    while (!en_C && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("abort_exec_reached", 64'(en_C), 64'd1);
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("abort_w_en", 64'(w_en), 64'd0);
    check("abort_idle", 64'(idle), 64'd1);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_quiet", 64'({en_A, en_B, en_C, en_status, done, illegal}), 64'd0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_write", 64'(w_en), 64'd0);
    end
    send(16'hD2AA); drain();

    check("queue_empty_at_end", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
